mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory port. It accepts word-aligned read and write requests over a req/ready handshake and serves them from an internal word RAM after a configurable number of wait states.
- Each response carries read data and an error flag.
- It replaces the fixed-latency memory so the control unit can be exercised against slow memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM (power of 2, at least 4).
- WAIT_STATES, 2, extra cycles spent in BUSY before the response (0..15).
- INIT_VALUE, 32'h0000_0000, value every word takes at reset.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- req  in  1  request valid; held by the initiator until ready.
- wr  in  1  1 = write, 0 = read; sampled with req.
- Address  in  32  byte address.
- WriteData  in  32  write data.
- ByteEn  in  4  write byte enables; ByteEn[i] selects bits 8i+7:8i.
- ready  out  1  one-cycle response strobe.
- ReadData  out  32  read result; valid when ready=1 and held until the next response.
- err  out  1  error flag, valid with ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; ready=0, err=0, busy=0, ReadData=0, wait counter=0.
  - Every RAM word is set to INIT_VALUE. Reset may take multiple cycles internally only if busy stays 1 and no request is accepted; the preferred implementation is a register-array clear in one cycle.
  - Reset mid-operation abandons the pending request: no write is performed and no ready is issued.
- State IDLE:
  - If req=1 at an edge, latch wr, Address, WriteData, ByteEn, load counter=WAIT_STATES, and go to BUSY.
  - Inputs are ignored after acceptance until the next IDLE.
- State BUSY:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access at this edge and go to RESP.
- Access rules, applied to the latched request:
  - Error condition: Address[1:0] != 0, or the word index Address[31:2] >= DEPTH_WORDS. On error: no RAM change, ReadData unchanged, err=1.
  - Read: ReadData <= RAM[Address[31:2]], err=0.
  - Write: for each i with ByteEn[i]=1, update RAM byte i from WriteData. ReadData unchanged, err=0. ByteEn=0000 is a legal no-op write.
- State RESP:
  - ready=1 and busy=1 for exactly this one cycle; err is valid in the same cycle.
  - Next edge: go to IDLE. A req sampled in RESP is not accepted; it is accepted in the following IDLE cycle.
- Latency: acceptance edge at cycle k, ready=1 during cycle k+WAIT_STATES+2.
  - WAIT_STATES=0 gives 2 cycles; the default gives 4.
  - Throughput is one request per WAIT_STATES+3 cycles.
- Read-after-write to the same word in consecutive requests returns the new data; there is no bypass hazard because accesses are serialized.
- err is cleared to 0 in every non-RESP cycle; ready is never high for two consecutive cycles.
- Initiator protocol violation: if req drops before ready, the latched request still completes and ready still pulses.

Test Plan:
1. Reset then read: hold reset=0 for 2 edges, then req=1, wr=0, Address=0x10 → ready=1 exactly 4 cycles after acceptance, ReadData=0x0000_0000, err=0, busy=1 from the acceptance edge through the ready cycle.
2. Full write and readback: write Address=0x20, WriteData=0xDEADBEEF, ByteEn=1111, then read 0x20 → ReadData=0xDEADBEEF, err=0 on both responses.
3. Partial write: with word 0x20=0xDEADBEEF, write WriteData=0x11223344, ByteEn=0101, then read → ReadData=0xDE22BE44.
4. Errors:
   - Read Address=0x22 (misaligned) → err=1, ReadData retains its previous value.
   - Write Address=0x400 with DEPTH_WORDS=256 → err=1; a subsequent read of 0x000 is unchanged.
5. Reset mid-request: write to 0x30 accepted, reset=0 during BUSY → ready never pulses, busy=0 after the edge, and a later read of 0x30 returns 0.
6. Back-to-back with req held high continuously and WAIT_STATES=0 → ready pulses every 3 cycles, and each response matches the request latched at its acceptance.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and mem_responder.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic        ready;
  logic [31:0] ReadData;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, Address, WriteData, ByteEn,
    input  ready, ReadData, err, busy
  );

  modport slave (
    input  req, wr, Address, WriteData, ByteEn,
    output ready, ReadData, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: word RAM served over a req/ready handshake.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic              w_accept;
  logic              w_access;

  logic              r_wr;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;

  logic              r_ready;
  logic              r_busy;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_err;
  logic [IDXW-1:0]   w_idx;

  // Misaligned or beyond the RAM: any set bit above the word index is out of range.
  assign w_err = (r_addr[1:0] != 2'b00) || (|r_addr[31:IDXW+2]);
  assign w_idx = r_addr[IDXW+1:2];

  // State and wait counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and access strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNTW'(WAIT_STATES);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end else begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request at acceptance; later bus activity is ignored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_wr    <= bus.wr;
      r_addr  <= bus.Address;
      r_wdata <= bus.WriteData;
      r_be    <= bus.ByteEn;
    end
  end

  // Registered response outputs, decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= (w_state_nxt == RESP);
      r_busy  <= (w_state_nxt != IDLE);
      r_err   <= w_access && w_err;
      if (w_access && !w_err && !r_wr) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Word RAM: cleared to INIT_VALUE in one reset cycle, byte-masked writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= INIT_VALUE;
      end
    end else if (w_access && !w_err && r_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.ReadData = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses 2 wait states, instance 1 uses 0.
module tb_mem_responder;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst   [2];
  logic        d_req   [2];
  logic        d_wr    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [3:0]  d_be    [2];

  wire  [1:0]  o_ready;
  wire  [1:0]  o_err;
  wire  [1:0]  o_busy;
  wire  [31:0] o_rdata [2];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    mem_responder_if b ();
    assign b.req       = d_req[g];
    assign b.wr        = d_wr[g];
    assign b.Address   = d_addr[g];
    assign b.WriteData = d_wdata[g];
    assign b.ByteEn    = d_be[g];
    assign o_ready[g]  = b.ready;
    assign o_err[g]    = b.err;
    assign o_busy[g]   = b.busy;
    assign o_rdata[g]  = b.ReadData;
    mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES((g == 0) ? 2 : 0),
      .INIT_VALUE (32'h0000_0000)
    ) dut (
      .clock(clk),
      .reset(d_rst[g]),
      .bus  (b)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Transaction-level reference: a response appears wait+1 edges after acceptance.
  logic [31:0] m_mem   [2][DEPTH];
  int          m_phase [2];
  int          m_left  [2];
  logic        m_wr    [2];
  logic [31:0] m_a     [2];
  logic [31:0] m_wd    [2];
  logic [3:0]  m_be    [2];
  bit          m_valid [2] = '{0, 0};
  logic        e_ready [2];
  logic        e_busy  [2];
  logic        e_err   [2];
  logic [31:0] e_rdata [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!d_rst[i]) begin
        for (int j = 0; j < int'(DEPTH); j++) m_mem[i][j] = 32'h0;
        m_phase[i] = 0;
        e_ready[i] = 0; e_busy[i] = 0; e_err[i] = 0; e_rdata[i] = 32'h0;
        m_valid[i] = 1;
      end else if (m_phase[i] == 0) begin
        e_ready[i] = 0; e_err[i] = 0;
        if (d_req[i]) begin
          m_wr[i] = d_wr[i]; m_a[i] = d_addr[i]; m_wd[i] = d_wdata[i]; m_be[i] = d_be[i];
          m_left[i] = wait_of(i) + 1;
          e_busy[i] = 1;
          m_phase[i] = 1;
        end else begin
          e_busy[i] = 0;
        end
      end else if (m_phase[i] == 1) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          if (m_a[i][1:0] != 2'b00 || m_a[i][31:2] >= 30'(DEPTH)) begin
            e_err[i] = 1;
          end else if (!m_wr[i]) begin
            e_rdata[i] = m_mem[i][m_a[i][9:2]];
            e_err[i] = 0;
          end else begin
            for (int k = 0; k < 4; k++)
              if (m_be[i][k]) m_mem[i][m_a[i][9:2]][8*k +: 8] = m_wd[i][8*k +: 8];
            e_err[i] = 0;
          end
          e_ready[i] = 1;
          m_phase[i] = 2;
        end
      end else begin
        e_ready[i] = 0; e_err[i] = 0; e_busy[i] = 0;
        m_phase[i] = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        chk($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(e_ready[i]));
        chk($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(e_busy[i]));
        chk($sformatf("err%0d", i),   32'(o_err[i]),   32'(e_err[i]));
        chk($sformatf("rdata%0d", i), o_rdata[i], e_rdata[i]);
      end
    end
  end

  // One request from idle; hold=0 drops req after the acceptance edge.
  task automatic xact(input int i, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input bit hold,
                      output logic [31:0] rd, output logic e, output int lat);
    bit got;
    got = 0;
    @(posedge clk); #1;
    d_req[i] = 1; d_wr[i] = w; d_addr[i] = a; d_wdata[i] = wd; d_be[i] = be;
    lat = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (!hold) d_req[i] = 0;
      if (o_ready[i]) begin
        got = 1;
        d_req[i] = 0;
      end
    end
    rd = o_rdata[i];
    e  = o_err[i];
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL timeout inst%0d addr %h: got no ready expected ready within 40 cycles", i, a);
      d_req[i] = 0;
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_rst[i] = 0; d_req[i] = 0; d_wr[i] = 0;
      d_addr[i] = 0; d_wdata[i] = 0; d_be[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy",  32'(o_busy[i]),  32'h0);
      chk("reset_ready", 32'(o_ready[i]), 32'h0);
      chk("reset_err",   32'(o_err[i]),   32'h0);
      chk("reset_rdata", o_rdata[i],      32'h0);
      d_rst[i] = 1;
    end

    // Read after reset with default latency.
    xact(0, 0, 32'h10, 32'h0, 4'h0, 1, rd, e, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_rdata", rd, 32'h0);
    chk("t1_err", 32'(e), 32'h0);

    // Full write and readback.
    xact(0, 1, 32'h20, 32'hDEADBEEF, 4'hF, 1, rd, e, lat);
    chk("t2_wr_err", 32'(e), 32'h0);
    xact(0, 0, 32'h20, 32'h0, 4'h0, 1, rd, e, lat);
    chk("t2_rdata", rd, 32'hDEADBEEF);
    chk("t2_rd_err", 32'(e), 32'h0);

    // Partial write of bytes 0 and 2.
    xact(0, 1, 32'h20, 32'h11223344, 4'b0101, 1, rd, e, lat);
    xact(0, 0, 32'h20, 32'h0, 4'h0, 1, rd, e, lat);
    chk("t3_rdata", rd, 32'hDE22BE44);

    // Misaligned read keeps ReadData; out-of-range write changes nothing.
    xact(0, 0, 32'h22, 32'h0, 4'h0, 1, rd, e, lat);
    chk("t4_misalign_err", 32'(e), 32'h1);
    chk("t4_misalign_rdata", rd, 32'hDE22BE44);
    xact(0, 1, 32'h400, 32'h55AA55AA, 4'hF, 1, rd, e, lat);
    chk("t4_oob_err", 32'(e), 32'h1);
    xact(0, 0, 32'h000, 32'h0, 4'h0, 1, rd, e, lat);
    chk("t4_word0", rd, 32'h0);
    chk("t4_word0_err", 32'(e), 32'h0);

    // Reset while a write is waiting in BUSY.
    @(posedge clk); #1;
    d_req[0] = 1; d_wr[0] = 1; d_addr[0] = 32'h30; d_wdata[0] = 32'hCAFEF00D; d_be[0] = 4'hF;
    @(posedge clk); #1;
    d_req[0] = 0;
    @(posedge clk); #1;
    chk("t5_busy_before", 32'(o_busy[0]), 32'h1);
    d_rst[0] = 0;
    @(posedge clk); #1;
    chk("t5_busy_after", 32'(o_busy[0]), 32'h0);
    chk("t5_ready_after", 32'(o_ready[0]), 32'h0);
    d_rst[0] = 1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("t5_no_ready", 32'(o_ready[0]), 32'h0);
    end
    xact(0, 0, 32'h30, 32'h0, 4'h0, 1, rd, e, lat);
    chk("t5_rdata", rd, 32'h0);

    // Back-to-back on the zero-wait instance with req held high and changing data.
    begin
      int last, pulses;
      last = -1; pulses = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
        d_req[1]   = 1;
        d_wr[1]    = 1'($urandom_range(0, 1));
        d_addr[1]  = 32'($urandom_range(0, 7)) << 2;
        d_wdata[1] = $urandom;
        d_be[1]    = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        if (o_ready[1]) begin
          if (last >= 0) chk("t6_period", 32'(c - last), 32'd3);
          last = c;
          pulses++;
        end
      end
      d_req[1] = 0;
      chk("t6_pulses", 32'(pulses), 32'd13);
      repeat (4) @(posedge clk);
    end

    // Randomized traffic on both instances, including errors and early req drop.
    for (int n = 0; n < 160; n++) begin
      int i, sel;
      logic [31:0] a;
      i   = n % 2;
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
      else               a = 32'($urandom_range(0, 15)) << 2;
      xact(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, rd, e, lat);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end
endmodule
